// File: rtl/image_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module   : image_capture_buffer
// Brief    : Frame capture buffer for pixel samples streamed over the Pi GPIO
//            bus. Frames are aligned by a start-of-frame strobe. Position is
//            tracked as row/column/channel counters plus a linear address.
//            The stored frame is read through a registered port. A small LED
//            debug view is selected by buttons.
//            Optional: define FRAME_CHECKSUM_EN for a 16-bit per-frame sum.
// Revision : 1.0 - initial release
// ============================================================================
module image_capture_buffer #(
    parameter  int HEIGHT   = 20,
    parameter  int WIDTH    = 30,
    parameter  int CHANNELS = 3,
    parameter  int DATA_W   = 8,
    parameter  int LED_ADDR = 10,
    localparam int SIZE     = HEIGHT * WIDTH * CHANNELS,
    localparam int ADDR_W   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                        pi_clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           gpio_pin,
    input  logic                        write_enable,
    input  logic                        sof,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        frame_valid,
    output logic                        busy,
    output logic [$clog2(HEIGHT):0]     pix_h,
    output logic [$clog2(WIDTH):0]      pix_w,
    output logic [$clog2(CHANNELS):0]   pix_c,
    output logic                        overflow,
    output logic                        sync_err,
    input  logic [1:0]                  buttons,
    output logic [5:0]                  LED,
    output logic [15:0]                 checksum
);

    localparam int HW = $clog2(HEIGHT) + 1;
    localparam int WW = $clog2(WIDTH) + 1;
    localparam int CW = $clog2(CHANNELS) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   mem [0:SIZE-1];
    logic [5:0]          mirror;

    // Accepted-sample decode: the position a sample lands on and the next one
    logic                wr;
    logic                last;
    logic [HW-1:0]       base_h;
    logic [WW-1:0]       base_w;
    logic [CW-1:0]       base_c;
    logic [ADDR_W-1:0]   base_addr;
    logic [HW-1:0]       nxt_h;
    logic [WW-1:0]       nxt_w;
    logic [CW-1:0]       nxt_c;
    logic [ADDR_W-1:0]   nxt_addr;

    // An sof sample always lands on position 0; otherwise on the current one
    always_comb begin
        wr        = write_enable && (sof || state == CAPTURE);
        base_h    = sof ? '0 : pix_h;
        base_w    = sof ? '0 : pix_w;
        base_c    = sof ? '0 : pix_c;
        base_addr = sof ? '0 : addr;
        last      = (base_addr == ADDR_W'(SIZE - 1));
        nxt_h     = base_h;
        nxt_w     = base_w;
        nxt_c     = base_c + 1'b1;
        nxt_addr  = base_addr + 1'b1;
        if (base_c == CW'(CHANNELS - 1)) begin
            nxt_c = '0;
            nxt_w = base_w + 1'b1;
            if (base_w == WW'(WIDTH - 1)) begin
                nxt_w = '0;
                nxt_h = base_h + 1'b1;
            end
        end
        if (last) begin
            nxt_h    = '0;
            nxt_w    = '0;
            nxt_c    = '0;
            nxt_addr = '0;
        end
    end

    // Capture state machine, position counters, sticky flags and LED mirror
    always_ff @(posedge pi_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            pix_h       <= '0;
            pix_w       <= '0;
            pix_c       <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            sync_err    <= 1'b0;
            mirror      <= '0;
        end else if (write_enable) begin
            if (wr) begin
                pix_h <= nxt_h;
                pix_w <= nxt_w;
                pix_c <= nxt_c;
                addr  <= nxt_addr;
                // An sof that interrupts a frame in progress is a sync error
                if (sof && state == CAPTURE) begin
                    sync_err <= 1'b1;
                end
                if (last) begin
                    state       <= DONE;
                    frame_valid <= 1'b1;
                    busy        <= 1'b0;
                end else begin
                    state       <= CAPTURE;
                    frame_valid <= 1'b0;
                    busy        <= 1'b1;
                end
                if (32'(base_addr) == LED_ADDR) begin
                    mirror <= 6'(gpio_pin);
                end
            end else if (state == IDLE) begin
                sync_err <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    // Sample storage; contents survive reset
    always_ff @(posedge pi_clk) begin
        if (wr) begin
            mem[base_addr] <= gpio_pin;
        end
    end

    // Registered read port; out-of-range addresses read as zero
    always_ff @(posedge pi_clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (32'(rd_addr) < SIZE) ? mem[rd_addr] : '0;
        end
    end

    // LED debug view selection
    always_comb begin
        LED = '0;
        case (buttons)
            2'b00:   LED = mirror;
            2'b01:   LED = {frame_valid, busy, overflow, sync_err, state};
            2'b10:   LED = 6'(pix_h);
            default: LED = 6'(pix_w);
        endcase
    end

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] sum;
    logic [15:0] sum_nxt;

    assign sum_nxt = (sof ? 16'd0 : sum) + 16'(gpio_pin);

    // Running frame sum, latched into checksum when the frame completes
    always_ff @(posedge pi_clk or posedge rst) begin
        if (rst) begin
            sum      <= '0;
            checksum <= '0;
        end else if (wr) begin
            sum <= sum_nxt;
            if (last) begin
                checksum <= sum_nxt;
            end
        end
    end
`else
    assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_image_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_capture_buffer
// Brief    : Self-checking bench for image_capture_buffer (2x3x3 frame) with a
//            behavioural frame model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_capture_buffer;

    localparam int H  = 2;
    localparam int W  = 3;
    localparam int C  = 3;
    localparam int SZ = H * W * C;
    localparam int LA = 10;

    logic       pi_clk = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] gpio_pin = '0;
    logic       write_enable = 1'b0;
    logic       sof = 1'b0;
    logic       rd_en = 1'b0;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       frame_valid;
    logic       busy;
    logic [1:0] pix_h;
    logic [2:0] pix_w;
    logic [2:0] pix_c;
    logic       overflow;
    logic       sync_err;
    logic [1:0] buttons = 2'b01;
    logic [5:0] LED;
    logic [15:0] checksum;

    int tests = 0;
    int fails = 0;

    image_capture_buffer #(
        .HEIGHT(H), .WIDTH(W), .CHANNELS(C), .DATA_W(8), .LED_ADDR(LA)
    ) dut (
        .pi_clk(pi_clk), .rst(rst), .gpio_pin(gpio_pin),
        .write_enable(write_enable), .sof(sof), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .frame_valid(frame_valid),
        .busy(busy), .pix_h(pix_h), .pix_w(pix_w), .pix_c(pix_c),
        .overflow(overflow), .sync_err(sync_err), .buttons(buttons),
        .LED(LED), .checksum(checksum)
    );

    always #5 pi_clk = ~pi_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_state: 0 idle, 1 capturing, 2 frame held; m_idx: next linear sample index
    int         m_state = 0;
    int         m_idx = 0;
    bit         m_fv = 0, m_ovf = 0, m_serr = 0, m_store = 0;
    logic [7:0] m_mem [SZ];
    bit         m_known [SZ];
    logic [7:0] m_rd = '0;
    bit         m_rd_known = 1;
    logic [5:0] m_mirror = '0;
    logic [15:0] m_sum = '0, m_chk = '0;

    always @(posedge pi_clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_idx = 0; m_fv = 0; m_ovf = 0; m_serr = 0;
            m_rd = '0; m_rd_known = 1; m_mirror = '0; m_sum = '0; m_chk = '0;
        end else begin
            if (rd_en) begin
                if (rd_addr < SZ) begin
                    m_rd = m_mem[rd_addr];
                    m_rd_known = m_known[rd_addr];
                end else begin
                    m_rd = '0;
                    m_rd_known = 1;
                end
            end
            m_store = 0;
            if (write_enable) begin
                if (sof) begin
                    if (m_state == 1) m_serr = 1;
                    m_idx = 0; m_sum = '0; m_state = 1; m_fv = 0; m_store = 1;
                end else if (m_state == 0) m_serr = 1;
                else if (m_state == 2) m_ovf = 1;
                else m_store = 1;
            end
            if (m_store) begin
                m_mem[m_idx] = gpio_pin;
                m_known[m_idx] = 1;
                if (m_idx == LA) m_mirror = gpio_pin[5:0];
                m_sum = m_sum + 16'(gpio_pin);
                m_idx++;
                if (m_idx == SZ) begin
                    m_idx = 0; m_state = 2; m_fv = 1; m_chk = m_sum;
                end
            end
        end
    end

    function automatic logic [5:0] led_exp(input logic [1:0] b);
        case (b)
            2'b00:   return m_mirror;
            2'b01:   return {m_fv, m_state == 1, m_ovf, m_serr, 2'(m_state)};
            2'b10:   return 6'(m_idx / (W * C));
            default: return 6'((m_idx / C) % W);
        endcase
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge pi_clk) begin
        chk("frame_valid", frame_valid, m_fv);
        chk("busy", busy, m_state == 1);
        chk("overflow", overflow, m_ovf);
        chk("sync_err", sync_err, m_serr);
        chk("pix_h", pix_h, m_idx / (W * C));
        chk("pix_w", pix_w, (m_idx / C) % W);
        chk("pix_c", pix_c, m_idx % C);
        if (m_rd_known) chk("rd_data", rd_data, m_rd);
        chk("LED", LED, led_exp(buttons));
`ifdef FRAME_CHECKSUM_EN
        chk("checksum", checksum, m_chk);
`else
        chk("checksum", checksum, 0);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic put(input logic [7:0] d, input logic s);
        gpio_pin = d; sof = s; write_enable = 1'b1;
        @(posedge pi_clk); #1;
        write_enable = 1'b0; sof = 1'b0;
    endtask

    task automatic put_rd(input logic [7:0] d, input logic s, input logic [4:0] a);
        rd_en = 1'b1; rd_addr = a;
        put(d, s);
        rd_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        rd_en = 1'b1; rd_addr = a;
        @(posedge pi_clk); #1;
        rd_en = 1'b0;
    endtask

    initial begin
        #22 rst = 1'b0;
        #1;
        chk("reset frame_valid", frame_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset LED view01", LED, 6'h00);
        @(posedge pi_clk); #1;

        // Full frame 0x00..0x11
        put(8'h00, 1'b1);
        for (int i = 1; i < SZ; i++) put(8'(i), 1'b0);
        chk("t1 frame_valid", frame_valid, 1);
        chk("t1 busy", busy, 0);
`ifdef FRAME_CHECKSUM_EN
        chk("t1 checksum", checksum, 16'h0099);
`endif
        for (int i = 0; i < SZ; i++) begin
            rd(5'(i));
            chk("t1 readback", rd_data, i);
        end
        buttons = 2'b00; #1;
        chk("t1 LED mirror", LED, 6'h0A);

        // Overflow after a full frame, then restart with 0xAA
        put(8'h20, 1'b0);
        put(8'h21, 1'b0);
        chk("t3 overflow", overflow, 1);
        rd(5'd1);
        chk("t3 mem unchanged", rd_data, 8'h01);
        put(8'hAA, 1'b1);
        chk("t3 frame_valid cleared", frame_valid, 0);
        chk("t3 busy", busy, 1);
        rd(5'd0);
        chk("t3 addr0", rd_data, 8'hAA);
        for (int i = 1; i < SZ; i++) begin
            buttons = 2'(i);
            put(8'(i), 1'b0);
        end
`ifdef FRAME_CHECKSUM_EN
        chk("t3 checksum", checksum, 16'h0143);
`endif

        // Same-edge read/write at addr 4, then sof restart at sample 7
        put(8'h50, 1'b1);
        put(8'h51, 1'b0);
        put(8'h52, 1'b0);
        put(8'h53, 1'b0);
        put_rd(8'h55, 1'b0, 5'd4);
        chk("t6 read old", rd_data, 8'h04);
        rd(5'd4);
        chk("t6 read new", rd_data, 8'h55);
        put(8'h56, 1'b0);
        put(8'h57, 1'b0);
        chk("t4 no sync_err yet", sync_err, 0);
        put(8'h60, 1'b1);
        chk("t4 sync_err", sync_err, 1);
        chk("t4 pix_h", pix_h, 0);
        chk("t4 pix_w", pix_w, 0);
        chk("t4 pix_c", pix_c, 1);
        for (int i = 1; i < SZ - 1; i++) begin
            buttons = 2'(i + 1);
            put(8'(8'h60 + i), 1'b0);
        end
        chk("t4 not yet done", frame_valid, 0);
        put(8'h71, 1'b0);
        chk("t4 done", frame_valid, 1);

        // Asynchronous reset mid-frame
        buttons = 2'b01;
        for (int i = 0; i < 9; i++) put(8'(i), i == 0);
        #2 rst = 1'b1;
        #1;
        chk("t5 busy", busy, 0);
        chk("t5 frame_valid", frame_valid, 0);
        chk("t5 pix_c", pix_c, 0);
        chk("t5 pix_w", pix_w, 0);
        chk("t5 sync_err", sync_err, 0);
        chk("t5 rd_data", rd_data, 0);
        chk("t5 LED", LED, 6'h00);
        chk("t5 checksum", checksum, 0);
        @(negedge pi_clk); #2 rst = 1'b0;
        @(posedge pi_clk); #1;
        rd(5'd1);
        chk("t5 kept mem", rd_data, 8'h01);
        rd(5'd20);
        chk("t5 out of range", rd_data, 0);

        // Sample without sof in IDLE
        put(8'h77, 1'b0);
        chk("t2 sync_err", sync_err, 1);
        chk("t2 busy", busy, 0);
        chk("t2 LED view01", LED, 6'h04);
        rd(5'd9);
        chk("t2 addr9 untouched", rd_data, 8'h69);
        for (int i = 0; i < SZ; i++) put(8'(8'h80 + i), i == 0);
        chk("t2 frame_valid", frame_valid, 1);
        rd(5'd17);
        chk("t2 addr17", rd_data, 8'h91);

        repeat (2) @(posedge pi_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
